// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Drives the ICache address, tracks the single outstanding fetch, and feeds a
// registered IF/ID pipeline register backed by a 1-entry skid buffer. Handles
// ICache misses, decode back-pressure and branch redirects, including a
// redirect that lands while a miss is still outstanding.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] FetchPc,
    input  logic [31:0] Inst,
    input  logic        IStall,
    input  logic        DecStall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    output logic [31:0] IfIdInst,
    output logic [31:0] IfIdPc,
    output logic        IfIdValid
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HOLD       = 2'd1,
        ST_REDIR_PEND = 2'd2
    } state_t;

    // Word-align a target address (instructions are 4-byte aligned).
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Next sequential fetch address, wrapping at the top of the address space.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] inflight_pc_r;
    logic        inflight_valid_r;
    logic        discard_r;
    logic [31:0] redir_tgt_r;
    logic        skid_valid_r;
    logic [31:0] skid_inst_r;
    logic [31:0] skid_pc_r;
    logic        ifid_valid_r;
    logic [31:0] ifid_inst_r;
    logic [31:0] ifid_pc_r;

    logic [31:0] fetch_pc_s;
    logic        accept_s;
    logic        to_ifid_s;
    logic        to_skid_s;
    logic        issue_gate_s;
    logic        issue_s;

    // Fetch address selection and the per-cycle accept/issue decisions.
    always_comb begin
        fetch_pc_s   = pc_r;
        issue_gate_s = 1'b0;

        // During a miss or while a redirect waits for the miss to resolve, the
        // cache must keep seeing the address it is working on.
        if (IStall || (state_r == ST_REDIR_PEND)) begin
            fetch_pc_s = inflight_pc_r;
        end else begin
            fetch_pc_s = pc_r;
        end

        accept_s  = inflight_valid_r && !IStall && !discard_r && (state_r == ST_RUN);
        to_ifid_s = accept_s && (!ifid_valid_r || !DecStall);
        to_skid_s = accept_s && ifid_valid_r && DecStall;

        // A HOLD cycle in which decode frees up hands the skid to IF/ID at the
        // edge, so a fetch may go out in that same cycle to avoid a bubble.
        case (state_r)
            ST_RUN:  issue_gate_s = !skid_valid_r;
            ST_HOLD: issue_gate_s = !DecStall;
            default: issue_gate_s = 1'b0;
        endcase

        // When the arriving word is about to fill the skid, nothing else may be
        // launched: pc_r already names the next sequential word, so it is
        // simply refetched once the skid drains.
        issue_s = issue_gate_s && !IStall && !Redirect && !to_skid_s;
    end

    assign FetchPc   = fetch_pc_s;
    assign IfIdInst  = ifid_inst_r;
    assign IfIdPc    = ifid_pc_r;
    assign IfIdValid = ifid_valid_r;

    // Fetch control FSM together with PC, in-flight tracking, skid and IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_RUN;
            pc_r             <= RESET_PC;
            inflight_pc_r    <= RESET_PC;
            inflight_valid_r <= 1'b0;
            discard_r        <= 1'b0;
            redir_tgt_r      <= RESET_PC;
            skid_valid_r     <= 1'b0;
            skid_inst_r      <= 32'h0000_0000;
            skid_pc_r        <= 32'h0000_0000;
            ifid_valid_r     <= 1'b0;
            ifid_inst_r      <= 32'h0000_0000;
            ifid_pc_r        <= 32'h0000_0000;
        end else begin
            discard_r <= 1'b0;

            // Whatever address the cache was given this cycle is what it will
            // answer (or keep missing on) next cycle.
            if (!IStall) begin
                inflight_pc_r <= fetch_pc_s;
            end

            if (Redirect) begin
                // Redirect outranks back-pressure, HOLD and any arriving word.
                ifid_valid_r     <= 1'b0;
                skid_valid_r     <= 1'b0;
                inflight_valid_r <= 1'b0;
                if (IStall) begin
                    redir_tgt_r <= align_pc(RedirectPc);
                    state_r     <= ST_REDIR_PEND;
                end else begin
                    pc_r      <= align_pc(RedirectPc);
                    discard_r <= 1'b1;
                    state_r   <= ST_RUN;
                end
            end else begin
                case (state_r)
                    ST_REDIR_PEND: begin
                        // The miss word returns now and is thrown away.
                        if (!IStall) begin
                            pc_r    <= redir_tgt_r;
                            state_r <= ST_RUN;
                        end
                    end
                    ST_HOLD: begin
                        if (!DecStall) begin
                            ifid_valid_r <= 1'b1;
                            ifid_inst_r  <= skid_inst_r;
                            ifid_pc_r    <= skid_pc_r;
                            skid_valid_r <= 1'b0;
                            state_r      <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (to_ifid_s) begin
                            ifid_valid_r <= 1'b1;
                            ifid_inst_r  <= Inst;
                            ifid_pc_r    <= inflight_pc_r;
                        end else if (to_skid_s) begin
                            skid_valid_r <= 1'b1;
                            skid_inst_r  <= Inst;
                            skid_pc_r    <= inflight_pc_r;
                            state_r      <= ST_HOLD;
                        end else if (!DecStall) begin
                            ifid_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_RUN;
                    end
                endcase

                if (issue_s) begin
                    pc_r             <= next_seq_pc(pc_r);
                    inflight_valid_r <= 1'b1;
                end else if (!IStall) begin
                    inflight_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, the first fetch address after reset.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 FetchPc  out  32  address driven to the ICache Addr input.
REQ-005 Inst  in  32  ICache response word.
REQ-006 IStall  in  1  ICache miss; high means no response this cycle.
REQ-007 DecStall  in  1  decode stage cannot accept; IF/ID SHALL hold.
REQ-008 Redirect  in  1  branch/jump taken; flush and refetch.
REQ-009 RedirectPc  in  32  redirect target.
REQ-010 IfIdInst  out  32  registered instruction to decode.
REQ-011 IfIdPc  out  32  registered PC of IfIdInst.
REQ-012 IfIdValid  out  1  IfIdInst/IfIdPc hold a live instruction.

Function
REQ-013 ICache contract: when IStall is low in cycle t+1, Inst is the word for the FetchPc of cycle t; the unit SHALL track that address in InFlightPc/InFlightValid.
REQ-014 FetchPc SHALL equal InFlightPc whenever IStall is high or a pending redirect is held, else PcReg; FetchPc SHALL be stable for every cycle of a miss.
REQ-015 Issue condition: state RUN, IStall low, skid empty, Redirect low; on issue PcReg <= PcReg+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), InFlightPc <= FetchPc, InFlightValid <= 1.
REQ-016 Response accepted when InFlightValid and IStall is low and no discard is flagged; an accepted word goes to IF/ID if IF/ID is empty or not held by DecStall, otherwise into the 1-entry skid buffer.
REQ-017 While the skid is full, state SHALL be HOLD: no issue, InFlightValid <= 0, PcReg held at the next sequential address.
REQ-018 HOLD -> RUN on the edge where DecStall is low; on that edge IF/ID loads the skid entry and the skid empties.
REQ-019 DecStall high SHALL keep IfIdInst/IfIdPc/IfIdValid unchanged, except on Redirect.
REQ-020 Redirect with IStall low: at that edge IfIdValid, the skid and InFlightValid SHALL clear; PcReg <= {RedirectPc[31:2],2'b00}; the next cycle's response SHALL be dropped.
REQ-021 Redirect with IStall high: the target SHALL be latched and state set to REDIR_PEND; IfIdValid and the skid SHALL clear immediately; FetchPc SHALL stay at InFlightPc.
REQ-022 REDIR_PEND -> RUN on the first edge with IStall low; that response SHALL be discarded and PcReg loaded from the latched target.
REQ-023 A Redirect arriving while in REDIR_PEND SHALL overwrite the latched target; the newest target wins.
REQ-024 Redirect SHALL have priority over DecStall, HOLD and response acceptance in the same cycle.
REQ-025 Throughput: with no misses, stalls or redirects, IfIdValid SHALL stay high with IfIdPc incrementing by 4 every cycle, one cycle after the first issue.

Reset
REQ-026 While rst is high: PcReg=RESET_PC, FetchPc=RESET_PC, InFlightValid=0, skid empty, state RUN, IfIdValid=0, IfIdInst=0, IfIdPc=0, pending redirect cleared.
REQ-027 Reset asserted mid-miss or mid-REDIR_PEND SHALL abandon the operation; the first issue after release SHALL be at RESET_PC.

Verification
REQ-028 Straight line: all hits from reset -> IfIdPc 0,4,8,C on consecutive cycles with IfIdValid=1; FetchPc leads IfIdPc by 8.
REQ-029 Miss: IStall high 3 cycles on PC 0x10 -> FetchPc held at 0x10 for all 3 cycles; IfIdPc=0x10 appears once, then 0x14 follows.
REQ-030 DecStall for 2 cycles with IfIdPc=0x20 -> IF/ID holds 0x20; 0x24 goes to the skid; on release 0x24 then 0x28 appear with no gap or duplicate.
REQ-031 Redirect to 0x103 with no miss -> IfIdValid=0 next cycle; next fetch at 0x100; the in-flight word is never presented.
REQ-032 Redirect to 0x200 during a miss, then to 0x300 before IStall drops -> FetchPc stays at the miss address; the miss word is discarded; fetch resumes at 0x300.
REQ-033 rst pulsed during a DecStall hold with the skid full -> all outputs at reset values; fetch restarts at RESET_PC.
